// File: rtl/alu_scheduler.sv
// ---------------------------------------------------------------------------
// alu_scheduler
//
// Shares one external combinational ALU among NREQ requesters. Arbitration is
// round-robin. Each accepted request uses a fixed three-state sequence:
//   IDLE : arbitrate, then latch the winner's operands on the accept edge
//   EXEC : drive the ALU from the operand registers for one cycle, then
//          capture its result and ZeroFlag
//   RESP : hold the response for the owner until its rsp_ready handshake
//
// Optional build macro: ALU_SCHED_OPCHECK_EN
//   When it is defined, the op code is checked on the accept edge. An illegal
//   op skips EXEC and answers with rsp_err=1, rsp_result=0 and rsp_zero=0.
//   When it is undefined, rsp_err is tied to 0.
//
// Parameters:
//   NREQ  number of requesters (2..4)
//   W     operand/result width
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req_valid/ready   per-requester request handshake (ready is one-hot/zero)
//   req_op/a/b/shamt  packed per-requester request fields (slice i = field i)
//   rsp_valid/ready   per-requester response handshake (valid is one-hot/zero)
//   rsp_result/zero   captured ALU result and ZeroFlag for the owner
//   rsp_err           illegal-op flag
//   alu_a/b/shamt/ctrl  operand registers driving the shared ALU
//   alu_result/zero   ALU outputs
// ---------------------------------------------------------------------------
module alu_scheduler #(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [4*NREQ-1:0]   req_op,
  input  logic [W*NREQ-1:0]   req_a,
  input  logic [W*NREQ-1:0]   req_b,
  input  logic [5*NREQ-1:0]   req_shamt,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [W-1:0]        rsp_result,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [4:0]          alu_shamt,
  output logic [3:0]          alu_ctrl,
  input  logic [W-1:0]        alu_result,
  input  logic                alu_zero
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [4:0]    shamt_q, shamt_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [W-1:0]  result_q, result_d;
  logic          zero_q, zero_d;
`ifdef ALU_SCHED_OPCHECK_EN
  logic          err_q, err_d;
`endif

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [3:0]    win_op;
  logic [W-1:0]  win_a;
  logic [W-1:0]  win_b;
  logic [4:0]    win_shamt;

  // Index base+k, wrapped modulo NREQ. k ranges over 1..NREQ.
  function automatic logic [IW-1:0] wrap_next(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[IW-1:0];
  endfunction

`ifdef ALU_SCHED_OPCHECK_EN
  function automatic logic legal_op(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b0101, 4'b0110, 4'b0111, 4'b1000,
      4'b1001, 4'b1010, 4'b1100, 4'b1110: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction
`endif

  // Round-robin search. It starts just after the last granted requester, so
  // each requester waits for at most NREQ-1 grants.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req_valid[wrap_next(last_grant_q, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_next(last_grant_q, k);
      end
    end
  end

  assign win_op    = req_op[4*int'(win_idx) +: 4];
  assign win_a     = req_a[W*int'(win_idx) +: W];
  assign win_b     = req_b[W*int'(win_idx) +: W];
  assign win_shamt = req_shamt[5*int'(win_idx) +: 5];

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    shamt_d      = shamt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    zero_d       = zero_q;
`ifdef ALU_SCHED_OPCHECK_EN
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A winner always has ready asserted, so a winner means an accept.
        if (win_found) begin
          op_d    = win_op;
          a_d     = win_a;
          b_d     = win_b;
          shamt_d = win_shamt;
          owner_d = win_idx;
          state_d = S_EXEC;
`ifdef ALU_SCHED_OPCHECK_EN
          if (!legal_op(win_op)) begin
            state_d  = S_RESP;
            err_d    = 1'b1;
            result_d = '0;
            zero_d   = 1'b0;
          end else begin
            err_d    = 1'b0;
          end
`endif
        end
      end
      S_EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = S_RESP;
      end
      S_RESP: begin
        // Only the owner's rsp_ready counts. The other bits are ignored.
        if (rsp_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      shamt_q      <= '0;
      owner_q      <= '0;
      last_grant_q <= LAST_INIT;
      result_q     <= '0;
      zero_q       <= 1'b0;
`ifdef ALU_SCHED_OPCHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      shamt_q      <= shamt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
`ifdef ALU_SCHED_OPCHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == S_IDLE && win_found) req_ready[win_idx] = 1'b1;
    if (state_q == S_RESP)              rsp_valid[owner_q] = 1'b1;
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_shamt  = shamt_q;
  assign alu_ctrl   = op_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
`ifdef ALU_SCHED_OPCHECK_EN
  assign rsp_err    = err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule
